mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one W-bit 4:1 mux among four requesters.
//  Grants one requester at a time and drives the mux selects (s1,s2) from the grant.
//  Gates the mux output with a valid flag.
//  Sits between requesters and the shared output line; first user of the 4:1 mux as a managed resource.
// PARAMETERS
//  W         1   data width of each mux input and of o
//  MAX_HOLD  4   max consecutive grant cycles while another requester waits (>=1)
// PORTS
//  clk      in   1        single clock, rising edge
//  rst      in   1        asynchronous, active-high reset
//  req      in   4        request per requester; req[0]=a .. req[3]=d
//  a,b,c,d  in   W        requester data
//  gnt      out  4        one-hot grant, or all-zero
//  s1,s2    out  1        mux select, registered; {s1,s2}: 00=a 01=b 10=c 11=d
//  o        out  W        selected data; 0 when o_valid=0
//  o_valid  out  1        |gnt
// BEHAVIOUR
//  - Reset (async, immediate, also mid-grant):
//    state=IDLE, gnt=0, {s1,s2}=00, ptr=0, hold_cnt=0, o_valid=0, o=0.
//  - State: owner[1:0], ptr[1:0] (highest-priority index), hold_cnt, FSM {IDLE, GRANT}.
//  - Search order is circular, starting at ptr: ptr, ptr+1, ptr+2, ptr+3 mod 4.
//    Wrap-around: 3 -> 0.
//  - IDLE:
//    - req==0: stay IDLE.
//    - else: next edge owner=first set req in search order; GRANT; hold_cnt=0.
//    - Latency req->gnt = 1 cycle.
//  - GRANT, evaluated each edge:
//    - Release: req[owner]=0.
//      ptr<=owner+1; if any other req, grant first in order from owner+1 on the same edge
//      (no bubble), hold_cnt=0; else IDLE, gnt=0.
//    - Expiry: req[owner]=1 AND hold_cnt==MAX_HOLD-1 AND another req set.
//      ptr<=owner+1; grant first other requester from owner+1; hold_cnt=0.
//      The old owner is rescheduled last.
//    - Otherwise keep owner.
//      hold_cnt increments, saturating at MAX_HOLD-1.
//      A lone requester holds indefinitely.
//  - MAX_HOLD=1: competing requesters rotate every cycle.
//  - Outputs are registered from FSM state: gnt=onehot(owner) in GRANT, {s1,s2}=owner.
//    In IDLE, {s1,s2} holds its last value.
//  - o = o_valid ? mux(a,b,c,d,{s1,s2}) : 0; combinational from inputs and registered select.
//  - Requester must sample gnt and hold req for as long as it wants the line.
//    Dropping req frees the line at the next edge.
//  - A request newly set while another owns the line waits; no preemption before expiry.
//  - hold_cnt width = clog2(MAX_HOLD), minimum 1 bit.
// STRUCTURE
//  - Shared package mux_arb_pkg holds:
//    - FSM state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
//    - select encodings SEL_A=2'b00 .. SEL_D=2'b11.
//  - One sub-module: mux4_w #(W), a W-bit 4:1 mux with the same {s1,s2} mapping as the existing
//    1-bit 4:1 mux. The arbiter instantiates it; gating by o_valid stays in the arbiter.
//  - Round-robin pick function (ptr, mask) -> index is local to the arbiter.
// TESTING
//  - Reset: assert rst mid-cycle with req=4'b1111 -> gnt=0, o_valid=0, o=0, {s1,s2}=00
//    immediately, no clock.
//  - Single request: req=4'b0100, c=1 -> after 1 edge gnt=0100, {s1,s2}=10, o=1.
//    Held for 20 cycles.
//  - Back-to-back release: owner 0, req goes 0001->0010 -> next edge gnt=0010 with no idle cycle.
//    ptr=1.
//  - Fairness (MAX_HOLD=4): req=1111 from reset.
//    Grants 0,1,2,3,0, each lasting exactly 4 cycles; wrap 3->0 checked.
//  - MAX_HOLD=1: req=1010 constant -> gnt alternates 0010,1000 every cycle.
//  - Self-check: each cycle o === (o_valid ? input[{s1,s2}] : 0) and $countones(gnt)<=1.
//    Random req and data, 200 cycles.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM state and mux select encodings for the 4:1 mux arbiter
package mux_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;
endpackage

// File: rtl/mux4_w.sv
// mux4_w: W-bit 4:1 mux, {s1,s2} = 00:a 01:b 10:c 11:d
module mux4_w
    import mux_arb_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         s1,
    input  logic         s2,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] o
);
    // Route the selected input straight through
    always_comb o = ({s1, s2} == SEL_A) ? a : ({s1, s2} == SEL_B) ? b : ({s1, s2} == SEL_C) ? c : d;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one W-bit 4:1 mux among four requesters
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [3:0]   gnt,
    output logic         s1,
    output logic         s2,
    output logic [W-1:0] o,
    output logic         o_valid
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    ptr;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    others;
    logic [1:0]    first;
    logic [1:0]    nxt;
    logic [W-1:0]  mux_o;

    // First set bit of mask searching circularly from start; lowest offset wins
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] mask);
        pick = start;
        for (int i = 3; i >= 0; i--)
            if (mask[start + 2'(i)]) pick = start + 2'(i);
    endfunction

    // Candidates for the handover: everyone except the current owner
    always_comb begin
        others = req & ~(4'b0001 << owner);
        first  = pick(ptr, req);
        nxt    = pick(owner + 2'd1, others);
    end

    // Grant FSM: the owner keeps the line until it drops req or its hold budget expires under contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= SEL_A;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
        end else if (state == ST_IDLE) begin
            if (|req) begin
                state    <= ST_GRANT;
                owner    <= first;
                gnt      <= 4'b0001 << first;
                hold_cnt <= '0;
            end
        end else if (!req[owner] || (hold_cnt == HOLD_MAX && |others)) begin
            ptr <= owner + 2'd1;
            if (|others) begin
                owner    <= nxt;
                gnt      <= 4'b0001 << nxt;
                hold_cnt <= '0;
            end else begin
                state <= ST_IDLE;
                gnt   <= 4'b0000;
            end
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign {s1, s2} = owner;
    assign o_valid  = |gnt;
    assign o        = o_valid ? mux_o : '0;

    mux4_w #(.W(W)) u_mux (
        .s1(s1),
        .s2(s2),
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .o (mux_o)
    );
endmodule
